// File: rtl/peripheral_mpram_multiport_ahb4.sv
// Multi-port AHB-Lite slave in front of one shared word-wide RAM.
// Each port queues its transfer; a single arbiter grants one RAM access per cycle.
//   state  | meaning
//   S_IDLE | no transfer outstanding, zero-wait OKAY
//   S_WAIT | transfer captured, waiting for RAM grant
//   S_DONE | granted access completed, may accept the next transfer
//   S_ERR1 | first ERROR cycle (HREADYOUT low)
//   S_ERR2 | second ERROR cycle, new transfers ignored
module peripheral_mpram_multiport_ahb4 #(
  parameter int    PORTS     = 2,
  parameter int    MEM_DEPTH = 256,
  parameter int    PLEN      = 10,
  parameter int    XLEN      = 32,
  parameter string ARB_MODE  = "RR"
) (
  input  logic                             HCLK,
  input  logic                             HRESET,
  input  logic [PORTS-1:0]                 HSEL,
  input  logic [PORTS-1:0][PLEN-1:0]       HADDR,
  input  logic [PORTS-1:0][XLEN-1:0]       HWDATA,
  output logic [PORTS-1:0][XLEN-1:0]       HRDATA,
  input  logic [PORTS-1:0]                 HWRITE,
  input  logic [PORTS-1:0][2:0]            HSIZE,
  input  logic [PORTS-1:0][2:0]            HBURST,
  input  logic [PORTS-1:0][3:0]            HPROT,
  input  logic [PORTS-1:0]                 HMASTLOCK,
  input  logic [PORTS-1:0][1:0]            HTRANS,
  input  logic [PORTS-1:0]                 HREADY,
  output logic [PORTS-1:0]                 HREADYOUT,
  output logic [PORTS-1:0]                 HRESP
);

  localparam int BYTES = XLEN / 8;
  localparam int OFFW  = $clog2(BYTES);
  localparam int AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int PW    = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam bit FIXED = (ARB_MODE == "FIXED");

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DONE, S_ERR1, S_ERR2} state_t;

  state_t [PORTS-1:0]           state_q, state_d;
  logic   [PORTS-1:0][PLEN-1:0] addr_q;
  logic   [PORTS-1:0][2:0]      size_q;
  logic   [PORTS-1:0]           write_q;
  logic   [PORTS-1:0]           accept, bad;
  logic                         gnt_vld;
  logic   [PW-1:0]              gnt_idx, ptr_q;
  logic   [AW-1:0]              mem_a;
  logic   [BYTES-1:0]           byte_en;
  logic   [XLEN-1:0]            wr_word;
  logic   [XLEN-1:0]            mem [MEM_DEPTH];

  logic unused_ok;
  assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS};

  function automatic int scan_port(input int k, input logic [PW-1:0] ptr);
    return FIXED ? k : (int'(ptr) + k) % PORTS;
  endfunction

  always_comb begin
    accept = '0;
    bad    = '0;
    for (int p = 0; p < PORTS; p++) begin
      accept[p] = HSEL[p] & HREADY[p] & HTRANS[p][1] &
                  (state_q[p] == S_IDLE || state_q[p] == S_DONE);
      bad[p]    = (32'(HADDR[p][PLEN-1:OFFW]) >= MEM_DEPTH) ||
                  ((32'd8 << HSIZE[p]) > XLEN);
    end
  end

  // One RAM access per cycle; RR scan starts at the pointer, FIXED at port 0.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < PORTS; k++) begin
      if (!gnt_vld && state_q[scan_port(k, ptr_q)] == S_WAIT) begin
        gnt_vld = 1'b1;
        gnt_idx = PW'(scan_port(k, ptr_q));
      end
    end
  end

  // Lanes sharing the naturally aligned block of the offset are written; low bits beyond size ignored.
  always_comb begin
    mem_a   = AW'(addr_q[gnt_idx][PLEN-1:OFFW]);
    byte_en = '0;
    for (int b = 0; b < BYTES; b++)
      byte_en[b] = ((b >> size_q[gnt_idx]) == (int'(addr_q[gnt_idx][OFFW-1:0]) >> size_q[gnt_idx]));
    wr_word = mem[mem_a];
    for (int b = 0; b < BYTES; b++)
      if (byte_en[b]) wr_word[8*b +: 8] = HWDATA[gnt_idx][8*b +: 8];
  end

  always_comb begin
    state_d   = state_q;
    HREADYOUT = '1;
    HRESP     = '0;
    for (int p = 0; p < PORTS; p++) begin
      case (state_q[p])
        S_IDLE, S_DONE: state_d[p] = accept[p] ? (bad[p] ? S_ERR1 : S_WAIT) : S_IDLE;
        S_WAIT: begin
          HREADYOUT[p] = 1'b0;
          if (gnt_vld && gnt_idx == PW'(p)) state_d[p] = S_DONE;
        end
        S_ERR1: begin
          HREADYOUT[p] = 1'b0;
          HRESP[p]     = 1'b1;
          state_d[p]   = S_ERR2;
        end
        S_ERR2: begin
          HRESP[p]   = 1'b1;
          state_d[p] = S_IDLE;
        end
        default: state_d[p] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= {PORTS{S_IDLE}};
      ptr_q   <= '0;
      HRDATA  <= '0;
    end else begin
      state_q <= state_d;
      if (gnt_vld) begin
        ptr_q <= PW'((int'(gnt_idx) + 1) % PORTS);
        if (!write_q[gnt_idx]) HRDATA[gnt_idx] <= mem[mem_a];
      end
    end
  end

  always_ff @(posedge HCLK) begin
    for (int p = 0; p < PORTS; p++) begin
      if (accept[p]) begin
        addr_q[p]  <= HADDR[p];
        size_q[p]  <= HSIZE[p];
        write_q[p] <= HWRITE[p];
      end
    end
  end

  // RAM is never cleared; a write granted in a reset cycle is dropped.
  always_ff @(posedge HCLK) begin
    if (!HRESET && gnt_vld && write_q[gnt_idx]) mem[mem_a] <= wr_word;
  end

endmodule
